change_dispenser: RTL and testbench

Drives the coin hopper that pays out change after a vending transaction. It accepts a change amount in cents, handled as a multiple of 5, and pays it out greedily: quarters first, then dimes, then nickels. Each coin is a one-hot request that the hopper must acknowledge. This block is the output-side counterpart of the coin-accepting vending controller: it emits N/D/Q coin events instead of consuming them.

---
 rtl/change_dispenser.sv | 158 +++++++++++++++
 tb/tb_change_dispenser.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount greedily as quarters, then dimes,
// then nickels. Each coin is a one-hot request held until the hopper
// acknowledges it. If the hopper stays silent too long, the payout aborts.
//
// Handshake: a coin output (N/D/Q) is the request and Coin_ack is the
// response. The coin counts as paid on the first rising edge where both the
// coin output and Coin_ack are high. The request then drops on that same edge.
// Coin_ack seen at any other time has no effect.
module change_dispenser #(
  parameter int AMT_W       = 6,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [AMT_W-1:0] Amount,
  input  logic             Coin_ack,
  output logic             N,
  output logic             D,
  output logic             Q,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic [AMT_W-1:0] Returned,
  output logic [2:0]       Dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_REQ    = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [AMT_W-1:0] C_QUARTER = AMT_W'(25);
  localparam logic [AMT_W-1:0] C_DIME    = AMT_W'(10);
  localparam logic [AMT_W-1:0] C_NICKEL  = AMT_W'(5);

  state_t           r_state;
  logic [AMT_W-1:0] r_rem;
  logic [AMT_W-1:0] r_returned;
  logic [AMT_W-1:0] r_coin;
  logic [GAP_W-1:0] r_gap;
  logic [TMO_W-1:0] r_tmo;
  logic             r_n;
  logic             r_d;
  logic             r_q;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  // Payout sequencer: every output is a register updated here.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_returned <= '0;
      r_coin     <= '0;
      r_gap      <= '0;
      r_tmo      <= '0;
      r_n        <= 1'b0;
      r_d        <= 1'b0;
      r_q        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_rem      <= Amount;
            r_returned <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SELECT;
          end
        end

        S_SELECT: begin
          r_tmo <= '0;
          if (r_rem >= C_QUARTER) begin
            r_q     <= 1'b1;
            r_coin  <= C_QUARTER;
            r_state <= S_REQ;
          end else if (r_rem >= C_DIME) begin
            r_d     <= 1'b1;
            r_coin  <= C_DIME;
            r_state <= S_REQ;
          end else if (r_rem >= C_NICKEL) begin
            r_n     <= 1'b1;
            r_coin  <= C_NICKEL;
            r_state <= S_REQ;
          end else begin
            // A leftover of 1-4 cents cannot be paid, so it is an error.
            r_err   <= (r_rem != '0);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_REQ: begin
          if (Coin_ack) begin
            r_rem      <= r_rem - r_coin;
            r_returned <= r_returned + r_coin;
            r_n        <= 1'b0;
            r_d        <= 1'b0;
            r_q        <= 1'b0;
            r_gap      <= '0;
            r_state    <= (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
          end else if (r_tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
            r_n     <= 1'b0;
            r_d     <= 1'b0;
            r_q     <= 1'b0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_GAP: begin
          if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
            r_state <= S_SELECT;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign N         = r_n;
  assign D         = r_d;
  assign Q         = r_q;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Err       = r_err;
  assign Returned  = r_returned;
  assign Dbg_state = r_state;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser. It runs directed scenarios and then random
// payouts. A greedy-coin reference model pushes the expected coins and the
// expected result into queues, and a negedge monitor pops and compares them.
module tb_change_dispenser;

  localparam int AMT_W       = 6;
  localparam int GAP_CYCLES  = 2;
  localparam int ACK_TIMEOUT = 16;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic [AMT_W-1:0] Amount;
  logic             Coin_ack;
  logic             N, D, Q, Busy, Done, Err;
  logic [AMT_W-1:0] Returned;
  logic [2:0]       dbg_state;

  // Coin codes used by the scoreboard: 1 = nickel, 2 = dime, 3 = quarter.
  logic [1:0]       exp_coin_q[$];
  logic [AMT_W:0]   exp_res_q[$];   // {err, returned}

  int n_checks = 0;
  int n_fail   = 0;

  bit ack_en    = 1'b1;
  int ack_fixed = -1;

  change_dispenser #(
    .AMT_W(AMT_W), .GAP_CYCLES(GAP_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Amount(Amount),
    .Coin_ack(Coin_ack), .N(N), .D(D), .Q(Q), .Busy(Busy), .Done(Done),
    .Err(Err), .Returned(Returned), .Dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Greedy change: largest coin that still fits, repeated. Without acks only
  // the first coin is requested, and the payout ends with err and nothing paid.
  function automatic void model(input int amt, input bit acks,
                                output int exp_ret, output int exp_err);
    int rem;
    int coin;
    rem = amt;
    exp_ret = 0;
    exp_err = 0;
    while (rem >= 5) begin
      coin = (rem >= 25) ? 25 : (rem >= 10) ? 10 : 5;
      exp_coin_q.push_back((coin == 25) ? 2'd3 : (coin == 10) ? 2'd2 : 2'd1);
      if (!acks) begin
        exp_err = 1;
        break;
      end
      rem -= coin;
      exp_ret += coin;
    end
    if (acks && rem != 0) exp_err = 1;
    exp_res_q.push_back({exp_err[0], exp_ret[AMT_W-1:0]});
  endfunction

  // ---------------- hopper model (ack responder) ----------------
  initial begin
    int  wait_cnt;
    int  cur_delay;
    bit  armed;
    Coin_ack = 1'b0;
    wait_cnt = 0;
    cur_delay = 0;
    armed = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        Coin_ack = 1'b0;
        armed = 1'b0;
      end else if (Coin_ack) begin
        Coin_ack = 1'b0;
      end else if ((N | D | Q) && ack_en) begin
        if (!armed) begin
          armed = 1'b1;
          wait_cnt = 0;
          cur_delay = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
        end
        if (wait_cnt >= cur_delay) begin
          Coin_ack = 1'b1;
          armed = 1'b0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [2:0] mon_prev = 3'b000;
  int         mon_low  = 0;
  bit         mon_fell = 1'b0;

  always @(negedge Clk) begin
    logic [2:0] cur;
    logic [1:0] code;
    logic [AMT_W:0] er;
    cur = {Q, D, N};
    if (!Reset) begin
      mon_prev = 3'b000;
      mon_fell = 1'b0;
      mon_low  = 0;
    end else begin
      if (cur != 3'b000) begin
        check("coin_onehot", $countones(cur), 1);
        check("coin_busy", int'(Busy), 1);
      end
      if (cur != 3'b000 && mon_prev == 3'b000) begin
        code = Q ? 2'd3 : D ? 2'd2 : 2'd1;
        if (exp_coin_q.size() == 0) begin
          check("coin_unexpected", int'(code), 0);
        end else begin
          check("coin_kind", int'(code), int'(exp_coin_q.pop_front()));
        end
        if (mon_fell) check("gap_len", mon_low, GAP_CYCLES + 1);
      end
      if (cur == 3'b000 && mon_prev != 3'b000) mon_fell = 1'b1;
      if (cur == 3'b000) mon_low++;
      else mon_low = 0;
      if (Done) begin
        check("done_busy", int'(Busy), 1);
        if (exp_res_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          er = exp_res_q.pop_front();
          check("done_err", int'(Err), int'(er[AMT_W]));
          check("done_returned", int'(Returned), int'(er[AMT_W-1:0]));
        end
        mon_fell = 1'b0;
      end
      mon_prev = cur;
    end
  end

  // ---------------- driver ----------------
  task automatic run_txn(input int amt, input bit acks, input bit repulse,
                         output int first_k, output int done_k,
                         output int q_len, output int saw_d, output int saw_n);
    int exp_ret;
    int exp_err;
    bit rp_on;
    @(negedge Clk);
    ack_en = acks;
    model(amt, acks, exp_ret, exp_err);
    Start = 1'b1;
    Amount = AMT_W'(amt);
    Coin_ack = 1'($urandom_range(0, 1));  // must be ignored in IDLE
    first_k = -1;
    done_k = -1;
    q_len = 0;
    saw_d = 0;
    saw_n = 0;
    rp_on = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge Clk);
      if (k == 1 || rp_on) begin
        Start = 1'b0;
        rp_on = 1'b0;
      end
      if ((N | D | Q) && first_k < 0) begin
        first_k = k;
        if (repulse) begin
          Start = 1'b1;
          Amount = AMT_W'(25);
          rp_on = 1'b1;
        end
      end
      if (Q) q_len++;
      if (D) saw_d = 1;
      if (N) saw_n = 1;
      if (Done) begin
        done_k = k;
        break;
      end
    end
    if (done_k < 0) check("done_timeout", 0, 1);
    @(negedge Clk);
    Start = 1'b0;
    check("err_clears", int'(Err), 0);
    check("returned_holds", int'(Returned), exp_ret);
    check("idle_not_busy", int'(Busy), 0);
    ack_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fk, dk, ql, sd, sn;
    Reset = 1'b0;
    Start = 1'b0;
    Amount = '0;
    repeat (3) @(negedge Clk);
    check("rst_coins", int'({N, D, Q}), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check("rst_err", int'(Err), 0);
    check("rst_returned", int'(Returned), 0);
    Reset = 1'b1;
    @(negedge Clk);

    // 30 cents, hopper answers 1 cycle late: quarter then nickel, no dime.
    ack_fixed = 1;
    run_txn(30, 1'b1, 1'b0, fk, dk, ql, sd, sn);
    check("t1_no_dime", sd, 0);
    check("t1_nickel", sn, 1);
    ack_fixed = -1;

    // 60 cents: quarter, quarter, dime; first coin 2 edges after Start.
    run_txn(60, 1'b1, 1'b0, fk, dk, ql, sd, sn);
    check("t2_latency", fk, 2);
    check("t2_no_nickel", sn, 0);

    // Zero amount: Done 2 edges after Start, no coin.
    run_txn(0, 1'b1, 1'b0, fk, dk, ql, sd, sn);
    check("t3_done_latency", dk, 2);
    check("t3_no_coin", fk, -1);

    // 7 cents: one nickel, residue flagged.
    run_txn(7, 1'b1, 1'b0, fk, dk, ql, sd, sn);
    check("t3_7_nickel", sn, 1);

    // 35 cents with a silent hopper: quarter held for the full timeout.
    run_txn(35, 1'b0, 1'b0, fk, dk, ql, sd, sn);
    check("t4_q_len", ql, ACK_TIMEOUT);
    check("t4_no_dime", sd, 0);
    check("t4_no_nickel", sn, 0);

    // 15 cents with Start re-pulsed during the first request: ignored.
    run_txn(15, 1'b1, 1'b1, fk, dk, ql, sd, sn);
    check("t5_dime", sd, 1);
    check("t5_nickel", sn, 1);
    check("t5_no_quarter", ql, 0);

    // Reset while a dime is requested.
    @(negedge Clk);
    model(20, 1'b1, fk, dk);
    Start = 1'b1;
    Amount = AMT_W'(20);
    @(negedge Clk);
    Start = 1'b0;
    ack_en = 1'b0;
    for (int k = 0; k < 10 && !D; k++) @(negedge Clk);
    check("t6_dime_up", int'(D), 1);
    #2;
    Reset = 1'b0;
    #1;
    check("t6_rst_dime", int'(D), 0);
    check("t6_rst_busy", int'(Busy), 0);
    check("t6_rst_done", int'(Done), 0);
    exp_coin_q.delete();
    exp_res_q.delete();
    ack_en = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    run_txn(10, 1'b1, 1'b0, fk, dk, ql, sd, sn);
    check("t6_after_dime", sd, 1);

    // Random payouts, about one in six with a silent hopper.
    for (int i = 0; i < 40; i++) begin
      run_txn(int'($urandom_range(0, 63)), ($urandom_range(0, 5) != 0),
              1'b0, fk, dk, ql, sd, sn);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (3) @(negedge Clk);
    check("coin_q_empty", exp_coin_q.size(), 0);
    check("res_q_empty", exp_res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
